// File: rtl/tinyalu_requester.sv
// Command initiator for the TinyALU start/done protocol: one command in, one response out.
// Define TINYALU_REQ_TIMEOUT_EN to build the RUN-state watchdog (TIMEOUT_CYCLES).
module tinyalu_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_timeout,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_reset_n,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, ALU_RST, RESP} state_t;

    state_t state;
    logic   rst_hold;
    logic   is_run_op;
    logic   is_rst_op;

    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 4..255");
    end

    assign is_run_op = (cmd_op != 3'd0) && (cmd_op <= 3'd4);
    assign is_rst_op = (cmd_op == 3'b111);

`ifdef TINYALU_REQ_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expire;

    // Expiry is decided on the edge the counter would reach the limit; done still wins there.
    assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !alu_done;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rst_hold    <= 1'b0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result  <= 16'h0000;
            rsp_op      <= 3'd0;
            alu_start   <= 1'b0;
            alu_op      <= 3'd0;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_reset_n <= 1'b0;
            busy        <= 1'b0;
`ifdef TINYALU_REQ_TIMEOUT_EN
            wd_cnt      <= '0;
            rsp_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    alu_start   <= 1'b0;
                    alu_reset_n <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        alu_op    <= cmd_op;
                        alu_a     <= cmd_a;
                        alu_b     <= cmd_b;
                        rsp_op    <= cmd_op;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef TINYALU_REQ_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
                        wd_cnt      <= '0;
`endif
                        if (is_rst_op) begin
                            alu_reset_n <= 1'b0;
                            rst_hold    <= 1'b0;
                            state       <= ALU_RST;
                        end else if (is_run_op) begin
                            alu_start <= 1'b1;
                            state     <= RUN;
                        end else begin
                            // Non-computing opcodes: one start pulse, answer immediately.
                            alu_start  <= 1'b1;
                            rsp_result <= 16'h0000;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                RUN: begin
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        alu_start  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end
`ifdef TINYALU_REQ_TIMEOUT_EN
                    else if (wd_expire) begin
                        alu_start   <= 1'b0;
                        alu_reset_n <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_result  <= 16'h0000;
                        rst_hold    <= 1'b0;
                        state       <= ALU_RST;
                    end
                    wd_cnt <= wd_cnt + CNT_W'(1);
`endif
                end
                ALU_RST: begin
                    // Two cycles of ALU reset, then report with a zero result.
                    if (rst_hold) begin
                        alu_reset_n <= 1'b1;
                        rsp_result  <= 16'h0000;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        rst_hold <= 1'b1;
                    end
                end
                RESP: begin
                    alu_start <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        alu_op    <= 3'd0;
                        alu_a     <= 8'h00;
                        alu_b     <= 8'h00;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tinyalu_requester.sv
// Randomized self-checking bench for tinyalu_requester with a behavioural TinyALU stand-in.
`timescale 1ns/1ps
module tb_tinyalu_requester;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_timeout;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_reset_n;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        busy;

    int total = 0;
    int bad = 0;

    int   done_lat = 1;
    bit   never_done = 1'b0;
    logic spur = 1'b0;
    logic mdone;
    int   scnt;

    always #5 clk = ~clk;

    tinyalu_requester #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_reset_n(alu_reset_n), .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy)
    );

    function automatic logic [15:0] ref_calc(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // ALU stand-in: done pulses after done_lat cycles of start; result is junk outside done.
    assign alu_done   = mdone | spur;
    assign alu_result = mdone ? ref_calc(alu_op, alu_a, alu_b) : 16'hDEAD;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mdone <= 1'b0;
            scnt  <= 0;
        end else if (!alu_reset_n) begin
            mdone <= 1'b0;
            scnt  <= 0;
        end else if (alu_start && !mdone) begin
            scnt  <= scnt + 1;
            mdone <= !never_done && (scnt + 1 == done_lat);
        end else begin
            mdone <= 1'b0;
            scnt  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction from the IDLE negedge to the negedge after the response handshake.
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input bit nodone, input int hold, input bit spur_resp);
        bit is_run, to, got, opnd_ok, stable_ok, ready_ok, busy_ok;
        int starts, rstlow, cyc, waited, first_lat;
        int exp_starts, exp_rstlow, exp_lat;
        logic [15:0] exp_res, res0;
        logic [2:0]  op0;
        logic        to0;
        string t;
        is_run = (op >= 3'd1) && (op <= 3'd4);
        to = 1'b0;
`ifdef TINYALU_REQ_TIMEOUT_EN
        to = is_run && (nodone || (lat + 1 > int'(TO)));
`endif
        exp_res    = (is_run && !to) ? ref_calc(op, a, b) : 16'h0000;
        exp_starts = !is_run ? ((op == 3'b111) ? 0 : 1) : (to ? int'(TO) : lat + 1);
        exp_rstlow = ((op == 3'b111) || to) ? 2 : 0;
        exp_lat    = (op == 3'b111) ? 3 : (!is_run ? 1 : (to ? int'(TO) + 3 : lat + 2));
        got = 0; opnd_ok = 1; stable_ok = 1; ready_ok = 1; busy_ok = 1;
        starts = 0; rstlow = 0; waited = 0; first_lat = 0;
        res0 = 16'h0; op0 = 3'd0; to0 = 1'b0;
        t = $sformatf("op%0d a%0h b%0h", op, a, b);

        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        done_lat = lat; never_done = nodone;
        check({t, " cmd_ready"}, 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        cyc = 1;
        while (!got && cyc < 100) begin
            if (!busy) busy_ok = 0;
            if (alu_start) begin
                starts++;
                if (alu_op !== op || alu_a !== a || alu_b !== b) opnd_ok = 0;
            end
            if (!alu_reset_n) rstlow++;
            if (rsp_valid) begin
                if (first_lat == 0) begin
                    first_lat = cyc; res0 = rsp_result; op0 = rsp_op; to0 = rsp_timeout;
                end else if (rsp_result !== res0 || rsp_op !== op0 || rsp_timeout !== to0) begin
                    stable_ok = 0;
                end
                if (cmd_ready) ready_ok = 0;
                if (waited >= hold) begin
                    rsp_ready = 1'b1; spur = 1'b0; got = 1;
                end else begin
                    rsp_ready = 1'b0; spur = spur_resp; waited++;
                end
            end else if (cmd_ready) begin
                ready_ok = 0;
            end
            @(negedge clk);
            cyc++;
        end
        rsp_ready = 1'b0; spur = 1'b0; never_done = 1'b0;

        check({t, " rsp seen"}, 32'(got), 1);
        check({t, " latency"}, 32'(first_lat), 32'(exp_lat));
        check({t, " result"}, 32'(res0), 32'(exp_res));
        check({t, " rsp_op"}, 32'(op0), 32'(op));
        check({t, " timeout"}, 32'(to0), 32'(to));
        check({t, " start cycles"}, 32'(starts), 32'(exp_starts));
        check({t, " alu reset cycles"}, 32'(rstlow), 32'(exp_rstlow));
        check({t, " operands stable"}, 32'(opnd_ok), 1);
        check({t, " rsp stable"}, 32'(stable_ok), 1);
        check({t, " cmd_ready low busy"}, 32'(ready_ok), 1);
        check({t, " busy"}, 32'(busy_ok), 1);
        check({t, " post ready"}, 32'({cmd_ready, rsp_valid, busy}), 32'b100);
        check({t, " post alu"}, 32'({alu_start, alu_reset_n, alu_op, alu_a, alu_b}), 32'h1_0000 << 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        check("reset ready/valid/busy", 32'({cmd_ready, rsp_valid, busy}), 32'b100);
        check("reset rsp fields", 32'({rsp_result, rsp_op, rsp_timeout}), 0);
        check("reset alu drives", 32'({alu_start, alu_reset_n, alu_op, alu_a, alu_b}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("alu_reset_n release", 32'(alu_reset_n), 1);
        check("cmd_ready after reset", 32'(cmd_ready), 1);

        do_cmd(3'd1, 8'hFF, 8'h01, 1, 0, 0, 0);
        do_cmd(3'd4, 8'hFF, 8'hFF, 3, 0, 0, 0);
        do_cmd(3'd3, 8'hF0, 8'h3C, 2, 0, 5, 1);
        do_cmd(3'd0, 8'h12, 8'h34, 1, 0, 0, 0);
        do_cmd(3'd7, 8'h55, 8'hAA, 1, 0, 2, 1);
        do_cmd(3'd5, 8'h01, 8'h02, 1, 0, 1, 0);
        do_cmd(3'd6, 8'h03, 8'h04, 2, 0, 0, 0);
        do_cmd(3'd2, 8'hC3, 8'h5A, 4, 0, 3, 1);

        // Spurious done while idle must not produce a response.
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        check("idle spurious done", 32'({rsp_valid, busy, cmd_ready}), 32'b001);

`ifdef TINYALU_REQ_TIMEOUT_EN
        do_cmd(3'd1, 8'h10, 8'h20, 1, 1, 0, 0);
        do_cmd(3'd1, 8'h10, 8'h20, int'(TO) - 1, 0, 0, 0);
        do_cmd(3'd4, 8'h07, 8'h09, int'(TO), 0, 1, 0);
`endif

        // Reset in the middle of a mul.
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 8'h21; cmd_b = 8'h43; done_lat = 3;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid-run start high", 32'(alu_start), 1);
        reset = 1'b1;
        #1;
        check("mid-run reset alu", 32'({alu_start, alu_reset_n}), 0);
        check("mid-run reset rsp", 32'({rsp_valid, busy, cmd_ready}), 32'b001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid-run alu_reset_n release", 32'(alu_reset_n), 1);
        do_cmd(3'd1, 8'h7F, 8'h81, 1, 0, 0, 0);

        // Reset while a response is held.
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'h0F; cmd_b = 8'hFF; done_lat = 2;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mid-resp valid reached", 32'(rsp_valid), 1);
        reset = 1'b1;
        #1;
        check("mid-resp reset", 32'({rsp_valid, rsp_result, alu_reset_n}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                   int'($urandom_range(1, 5)), 0, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
